// File: rtl/ex_stage_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipeline
// Purpose  : Execute-stage wrapper placed between decode and memory. Captures
//            decoded ops in an ID/EX latch, resolves operand forwarding, drives
//            the external combinational ALU, and registers the ALU result in
//            an EX/MEM latch behind a valid/ready handshake.
//            Throughput: one op per cycle. Latency: 2 cycles.
// Ports    :
//   clk, rst                    clock (rising edge), async active-high reset
//   id_valid / id_ready         decode handshake
//   id_rs1_addr, id_rs2_addr,
//   id_rd_addr                  register indices of the decoded op
//   id_rs1_data, id_rs2_data    register-file read data
//   id_imm, id_use_imm          immediate and operand-B select
//   id_alu_op, id_reg_write     ALU opcode and destination write enable
//   flush                       synchronous kill of the ID/EX latch
//   mem_fwd_*, wb_fwd_*         forwarding sources from MEM and WB
//   alu_a, alu_b, alu_op        operands/opcode to the ALU
//   alu_result                  combinational ALU output
//   ex_valid / ex_ready         downstream handshake
//   ex_result, ex_rd_addr,
//   ex_reg_write                registered EX/MEM payload
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_pipeline #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // decode side
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_use_imm,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_reg_write,
  input  logic                  flush,
  // forwarding sources
  input  logic                  mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  // ALU interface
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [ALU_OP_W-1:0]   alu_op,
  input  logic [XLEN-1:0]       alu_result,
  // memory side
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_result,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write
);

  // --------------------------------------------------------------------------
  // ID/EX latch
  // --------------------------------------------------------------------------
  logic                  r_s1_valid;
  logic [REG_ADDR_W-1:0] r_s1_rs1_addr;
  logic [REG_ADDR_W-1:0] r_s1_rs2_addr;
  logic [REG_ADDR_W-1:0] r_s1_rd_addr;
  logic [XLEN-1:0]       r_s1_rs1_data;
  logic [XLEN-1:0]       r_s1_rs2_data;
  logic [XLEN-1:0]       r_s1_imm;
  logic                  r_s1_use_imm;
  logic [ALU_OP_W-1:0]   r_s1_alu_op;
  logic                  r_s1_reg_write;

  // --------------------------------------------------------------------------
  // EX/MEM latch
  // --------------------------------------------------------------------------
  logic                  r_ex_valid;
  logic [XLEN-1:0]       r_ex_result;
  logic [REG_ADDR_W-1:0] r_ex_rd_addr;
  logic                  r_ex_reg_write;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_advance;
  logic w_accept;
  logic w_id_ready;

  // Flush suppresses advance so a killed op can never reach EX/MEM.
  assign w_advance  = r_s1_valid & (~r_ex_valid | ex_ready) & ~flush;
  assign w_id_ready = ~flush & (~r_s1_valid | w_advance);
  assign w_accept   = id_valid & w_id_ready;

  // --------------------------------------------------------------------------
  // Operand forwarding: EX/MEM > MEM > WB > latched data. x0 never forwards.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  always_comb begin
    w_fwd_rs1 = r_s1_rs1_data;
    if (r_s1_rs1_addr != '0) begin
      if (r_ex_valid && r_ex_reg_write && (r_ex_rd_addr == r_s1_rs1_addr))
        w_fwd_rs1 = r_ex_result;
      else if (mem_fwd_valid && (mem_fwd_rd == r_s1_rs1_addr))
        w_fwd_rs1 = mem_fwd_data;
      else if (wb_fwd_valid && (wb_fwd_rd == r_s1_rs1_addr))
        w_fwd_rs1 = wb_fwd_data;
    end
  end

  always_comb begin
    w_fwd_rs2 = r_s1_rs2_data;
    if (r_s1_rs2_addr != '0) begin
      if (r_ex_valid && r_ex_reg_write && (r_ex_rd_addr == r_s1_rs2_addr))
        w_fwd_rs2 = r_ex_result;
      else if (mem_fwd_valid && (mem_fwd_rd == r_s1_rs2_addr))
        w_fwd_rs2 = mem_fwd_data;
      else if (wb_fwd_valid && (wb_fwd_rd == r_s1_rs2_addr))
        w_fwd_rs2 = wb_fwd_data;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX latch update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_rs1_addr  <= '0;
      r_s1_rs2_addr  <= '0;
      r_s1_rd_addr   <= '0;
      r_s1_rs1_data  <= '0;
      r_s1_rs2_data  <= '0;
      r_s1_imm       <= '0;
      r_s1_use_imm   <= 1'b0;
      r_s1_alu_op    <= '0;
      r_s1_reg_write <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid     <= 1'b1;
      r_s1_rs1_addr  <= id_rs1_addr;
      r_s1_rs2_addr  <= id_rs2_addr;
      r_s1_rd_addr   <= id_rd_addr;
      r_s1_rs1_data  <= id_rs1_data;
      r_s1_rs2_data  <= id_rs2_data;
      r_s1_imm       <= id_imm;
      r_s1_use_imm   <= id_use_imm;
      r_s1_alu_op    <= id_alu_op;
      r_s1_reg_write <= id_reg_write;
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end else if (r_s1_valid) begin
      // Stalled: capture forwarded operands so a producer that retires from
      // MEM/WB during the stall is not lost once it stops being forwarded.
      r_s1_rs1_data <= w_fwd_rs1;
      r_s1_rs2_data <= w_fwd_rs2;
    end
  end

  // --------------------------------------------------------------------------
  // EX/MEM latch update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_result    <= '0;
      r_ex_rd_addr   <= '0;
      r_ex_reg_write <= 1'b0;
    end else if (w_advance) begin
      r_ex_valid     <= 1'b1;
      r_ex_result    <= alu_result;
      r_ex_rd_addr   <= r_s1_rd_addr;
      r_ex_reg_write <= r_s1_reg_write;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign id_ready     = w_id_ready;
  assign alu_a        = w_fwd_rs1;
  assign alu_b        = r_s1_use_imm ? r_s1_imm : w_fwd_rs2;
  assign alu_op       = r_s1_alu_op;
  assign ex_valid     = r_ex_valid;
  assign ex_result    = r_ex_result;
  assign ex_rd_addr   = r_ex_rd_addr;
  assign ex_reg_write = r_ex_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_pipeline
// Purpose  : Directed self-checking bench for ex_stage_pipeline. A small ALU
//            model (ADD / SLL) closes the loop on alu_a/alu_b/alu_op.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_pipeline;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] c_OP_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] c_OP_SLL = 4'd1;

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic                  id_ready;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic                  id_use_imm;
  logic [ALU_OP_W-1:0]   id_alu_op;
  logic                  id_reg_write;
  logic                  flush;
  logic                  mem_fwd_valid;
  logic [REG_ADDR_W-1:0] mem_fwd_rd;
  logic [XLEN-1:0]       mem_fwd_data;
  logic                  wb_fwd_valid;
  logic [REG_ADDR_W-1:0] wb_fwd_rd;
  logic [XLEN-1:0]       wb_fwd_data;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [XLEN-1:0]       alu_result;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [XLEN-1:0]       ex_result;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;

  int n_cmp;
  int n_err;

  ex_stage_pipeline #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .ALU_OP_W   (ALU_OP_W)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rd_addr    (id_rd_addr),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_alu_op     (id_alu_op),
    .id_reg_write  (id_reg_write),
    .flush         (flush),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_result     (ex_result),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write)
  );

  // Reference ALU: ADD and SLL (shift amount from alu_b[4:0]).
  always_comb begin
    alu_result = alu_a;
    case (alu_op)
      c_OP_ADD: alu_result = alu_a + alu_b;
      c_OP_SLL: alu_result = alu_a << alu_b[4:0];
      default:  alu_result = alu_a;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [REG_ADDR_W-1:0] rs1, input logic [XLEN-1:0] rs1_d,
                          input logic [REG_ADDR_W-1:0] rs2, input logic [XLEN-1:0] rs2_d,
                          input logic [XLEN-1:0] imm, input logic use_imm,
                          input logic [ALU_OP_W-1:0] op, input logic [REG_ADDR_W-1:0] rd);
    id_valid     = 1'b1;
    id_rs1_addr  = rs1;
    id_rs1_data  = rs1_d;
    id_rs2_addr  = rs2;
    id_rs2_data  = rs2_d;
    id_imm       = imm;
    id_use_imm   = use_imm;
    id_alu_op    = op;
    id_rd_addr   = rd;
    id_reg_write = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_use_imm = 1'b0;
    id_alu_op = '0; id_reg_write = 1'b0; flush = 1'b0;
    mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    ex_ready = 1'b1;

    // ---------------- reset state
    #12;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_result", ex_result, 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd1);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---------------- back-to-back SLL
    drive_op(5'd1, 64'd5, 5'd0, 64'd0, 64'd3, 1'b1, c_OP_SLL, 5'd10);
    tick();
    drive_op(5'd2, 64'hFFFF, 5'd0, 64'd0, 64'd4, 1'b1, c_OP_SLL, 5'd11);
    #1;
    chk("b2b_alu_a", alu_a, 64'd5);
    chk("b2b_alu_b", alu_b, 64'd3);
    chk("b2b_alu_op", 64'(alu_op), 64'(c_OP_SLL));
    chk("b2b_lat_not_yet", 64'(ex_valid), 64'd0);
    chk("b2b_id_ready", 64'(id_ready), 64'd1);
    tick();
    id_valid = 1'b0;
    chk("b2b_v1", 64'(ex_valid), 64'd1);
    chk("b2b_res1", ex_result, 64'd40);
    chk("b2b_rd1", 64'(ex_rd_addr), 64'd10);
    tick();
    chk("b2b_v2", 64'(ex_valid), 64'd1);
    chk("b2b_res2", ex_result, 64'hFFFF0);
    chk("b2b_rd2", 64'(ex_rd_addr), 64'd11);
    tick();
    chk("b2b_drain", 64'(ex_valid), 64'd0);

    // ---------------- EX/MEM forward beats MEM
    drive_op(5'd0, 64'd7, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd3);
    tick();
    drive_op(5'd3, 64'd0, 5'd0, 64'd0, 64'd1, 1'b1, c_OP_ADD, 5'd4);
    tick();
    id_valid = 1'b0;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'd99;
    #1;
    chk("exfwd_alu_a", alu_a, 64'd7);
    chk("exfwd_prod", ex_result, 64'd7);
    tick();
    chk("exfwd_res", ex_result, 64'd8);
    mem_fwd_valid = 1'b0;
    tick();

    // ---------------- x0 never forwards
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 64'd55;
    drive_op(5'd0, 64'd0, 5'd0, 64'd0, 64'd2, 1'b1, c_OP_ADD, 5'd9);
    tick();
    id_valid = 1'b0;
    #1;
    chk("x0_alu_a", alu_a, 64'd0);
    tick();
    chk("x0_res", ex_result, 64'd2);
    mem_fwd_valid = 1'b0;
    tick();

    // ---------------- MEM beats WB on rs1; WB feeds rs2
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd12; mem_fwd_data = 64'hAA;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd12; wb_fwd_data  = 64'hBB;
    drive_op(5'd12, 64'd0, 5'd13, 64'd0, 64'd0, 1'b0, c_OP_ADD, 5'd14);
    tick();
    id_valid = 1'b0;
    wb_fwd_rd = 5'd13; wb_fwd_data = 64'hCC;
    #1;
    chk("memwb_alu_a", alu_a, 64'hAA);
    chk("memwb_alu_b", alu_b, 64'hCC);
    tick();
    chk("memwb_res", ex_result, 64'h176);
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    tick();

    // ---------------- stall with operand refresh
    ex_ready = 1'b0;
    drive_op(5'd0, 64'd1, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd5);
    tick();
    drive_op(5'd4, 64'd0, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd6);
    tick();
    id_valid = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 64'h1234;
    #1;
    chk("stall1_ex_valid", 64'(ex_valid), 64'd1);
    chk("stall1_ex_result", ex_result, 64'd1);
    chk("stall1_id_ready", 64'(id_ready), 64'd0);
    chk("stall1_alu_a", alu_a, 64'h1234);
    tick();
    wb_fwd_valid = 1'b0;
    #1;
    chk("stall2_alu_a", alu_a, 64'h1234);
    chk("stall2_ex_result", ex_result, 64'd1);
    chk("stall2_id_ready", 64'(id_ready), 64'd0);
    tick();
    chk("stall3_alu_a", alu_a, 64'h1234);
    chk("stall3_ex_result", ex_result, 64'd1);
    chk("stall3_ex_rd", 64'(ex_rd_addr), 64'd5);
    tick();
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", 64'(id_ready), 64'd1);
    tick();
    chk("release_valid", 64'(ex_valid), 64'd1);
    chk("release_res", ex_result, 64'h1234);
    chk("release_rd", 64'(ex_rd_addr), 64'd6);
    tick();
    chk("release_drain", 64'(ex_valid), 64'd0);

    // ---------------- flush while both latches hold ops
    ex_ready = 1'b0;
    drive_op(5'd0, 64'h77, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd7);
    tick();
    drive_op(5'd0, 64'h88, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd8);
    tick();
    id_valid = 1'b0;
    flush = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("flush_id_ready", 64'(id_ready), 64'd0);
    chk("flush_held_valid", 64'(ex_valid), 64'd1);
    chk("flush_held_res", ex_result, 64'h77);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_no_leak_v", 64'(ex_valid), 64'd0);
    chk("flush_no_leak_r", ex_result, 64'h77);
    chk("flush_id_ready_after", 64'(id_ready), 64'd1);
    tick();
    chk("flush_still_empty", 64'(ex_valid), 64'd0);

    // ---------------- async reset mid-stall
    ex_ready = 1'b0;
    drive_op(5'd0, 64'h55, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd1);
    tick();
    drive_op(5'd0, 64'h66, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd2);
    tick();
    id_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(ex_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ex_valid", 64'(ex_valid), 64'd0);
    chk("arst_ex_result", ex_result, 64'd0);
    chk("arst_ex_rd", 64'(ex_rd_addr), 64'd0);
    chk("arst_id_ready", 64'(id_ready), 64'd1);
    chk("arst_alu_a", alu_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    tick();
    chk("post_rst_quiet", 64'(ex_valid), 64'd0);
    drive_op(5'd0, 64'h3, 5'd0, 64'd0, 64'd0, 1'b1, c_OP_ADD, 5'd2);
    tick();
    id_valid = 1'b0;
    #1;
    chk("post_rst_lat1", 64'(ex_valid), 64'd0);
    tick();
    chk("post_rst_lat2", 64'(ex_valid), 64'd1);
    chk("post_rst_res", ex_result, 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
